// File: rtl/branch_predictor_if.sv
// Predictor <-> pipeline bundle: IF lookup plus ID-stage resolve/train.
// Carries pred_ghr/upd_ghr when BRANCH_PREDICTOR_GHISTORY_EN is defined.
interface branch_predictor_if #(
  parameter int PC_W   = 32,
  parameter int IDX_W  = 6,
  parameter int STAT_W = 16
);
  logic [PC_W-1:0]   pred_pc;
  logic              pred_taken;
  logic              upd_valid;
  logic [PC_W-1:0]   upd_pc;
  logic              upd_pred;
  logic              upd_taken;
  logic              mispredict;
  logic [STAT_W-1:0] branch_cnt;
  logic [STAT_W-1:0] miss_cnt;
`ifdef BRANCH_PREDICTOR_GHISTORY_EN
  logic [IDX_W-1:0]  pred_ghr;
  logic [IDX_W-1:0]  upd_ghr;

  modport master (
    output pred_pc, upd_valid, upd_pc,
           upd_pred, upd_taken, upd_ghr,
    input  pred_taken, mispredict,
           branch_cnt, miss_cnt, pred_ghr
  );
  modport slave (
    input  pred_pc, upd_valid, upd_pc,
           upd_pred, upd_taken, upd_ghr,
    output pred_taken, mispredict,
           branch_cnt, miss_cnt, pred_ghr
  );
`else
  modport master (
    output pred_pc, upd_valid, upd_pc,
           upd_pred, upd_taken,
    input  pred_taken, mispredict,
           branch_cnt, miss_cnt
  );
  modport slave (
    input  pred_pc, upd_valid, upd_pc,
           upd_pred, upd_taken,
    output pred_taken, mispredict,
           branch_cnt, miss_cnt
  );
`endif
endinterface

// File: rtl/branch_predictor.sv
// Saturating-counter branch predictor with mispredict stats.
// Define BRANCH_PREDICTOR_GHISTORY_EN for gshare (PC index ^ GHR).
module branch_predictor #(
  parameter int PC_W   = 32,
  parameter int IDX_W  = 6,
  parameter int CTR_W  = 2,
  parameter int STAT_W = 16
) (
  input  logic clk,
  input  logic rst,
  branch_predictor_if.slave bp
);
  localparam int N = 1 << IDX_W;
  localparam logic [CTR_W-1:0] CTR_RST =
    CTR_W'((1 << (CTR_W - 1)) - 1);
  localparam logic [CTR_W-1:0] CTR_MAX = {CTR_W{1'b1}};
  localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};

  logic [CTR_W-1:0]  ctr [N];
  logic [CTR_W-1:0]  ctr_cur;
  logic [CTR_W-1:0]  ctr_nxt;
  logic [IDX_W-1:0]  rd_idx;
  logic [IDX_W-1:0]  wr_idx;
  logic [STAT_W-1:0] branch_q;
  logic [STAT_W-1:0] miss_q;
  logic              miss;
  logic              unused_pc;

  assign unused_pc = ^{bp.pred_pc[PC_W-1:IDX_W+2],
                       bp.pred_pc[1:0],
                       bp.upd_pc[PC_W-1:IDX_W+2],
                       bp.upd_pc[1:0]};

`ifdef BRANCH_PREDICTOR_GHISTORY_EN
  logic [IDX_W-1:0] ghr;

  assign rd_idx = bp.pred_pc[IDX_W+1:2] ^ ghr;
  assign wr_idx = bp.upd_pc[IDX_W+1:2] ^ bp.upd_ghr;
  assign bp.pred_ghr = ghr;

  // History shifts on every resolve; mispredicts need no extra repair
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ghr <= '0;
    end else if (bp.upd_valid) begin
      ghr <= {ghr[IDX_W-2:0], bp.upd_taken};
    end
  end
`else
  assign rd_idx = bp.pred_pc[IDX_W+1:2];
  assign wr_idx = bp.upd_pc[IDX_W+1:2];
`endif

  // Read is the pre-update value; no write-to-read bypass
  assign bp.pred_taken = ctr[rd_idx][CTR_W-1];

  assign miss = bp.upd_valid &
                (bp.upd_pred ^ bp.upd_taken);
  assign bp.mispredict = miss;

  assign ctr_cur = ctr[wr_idx];

  always_comb begin
    ctr_nxt = ctr_cur;
    unique case (1'b1)
      bp.upd_taken && ctr_cur != CTR_MAX:
        ctr_nxt = ctr_cur + CTR_W'(1);
      !bp.upd_taken && ctr_cur != '0:
        ctr_nxt = ctr_cur - CTR_W'(1);
      default: ctr_nxt = ctr_cur;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        ctr[i] <= CTR_RST;
      end
    end else if (bp.upd_valid) begin
      ctr[wr_idx] <= ctr_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_q <= '0;
      miss_q   <= '0;
    end else if (bp.upd_valid) begin
      if (branch_q != STAT_MAX) begin
        branch_q <= branch_q + STAT_W'(1);
      end
      if (miss && miss_q != STAT_MAX) begin
        miss_q <= miss_q + STAT_W'(1);
      end
    end
  end

  assign bp.branch_cnt = branch_q;
  assign bp.miss_cnt   = miss_q;
endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor (PC-indexed build).
// STAT_W=4 so counter saturation is reachable quickly.
module tb_branch_predictor;
  localparam int PC_W   = 32;
  localparam int IDX_W  = 6;
  localparam int CTR_W  = 2;
  localparam int STAT_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass = 0;
  int   n_tot  = 0;

  always #5 clk = ~clk;

  branch_predictor_if #(
    .PC_W(PC_W), .IDX_W(IDX_W), .STAT_W(STAT_W)
  ) bp ();

  branch_predictor #(
    .PC_W(PC_W), .IDX_W(IDX_W),
    .CTR_W(CTR_W), .STAT_W(STAT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bp(bp)
  );

  task automatic idle();
    bp.upd_valid = 1'b0;
    bp.upd_pc    = '0;
    bp.upd_pred  = 1'b0;
    bp.upd_taken = 1'b0;
`ifdef BRANCH_PREDICTOR_GHISTORY_EN
    bp.upd_ghr   = '0;
`endif
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // One resolved branch, committed on the next rising edge
  task automatic upd(input logic [31:0] pc,
                     input logic tk,
                     input logic pr);
    bp.upd_valid = 1'b1;
    bp.upd_pc    = pc;
    bp.upd_taken = tk;
    bp.upd_pred  = pr;
    @(posedge clk);
    #1 idle();
  endtask

  task automatic test_reset();
    idle();
    bp.pred_pc = 32'h40;
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    n_tot++;
    if (bp.pred_taken !== 1'b0) begin
      $display("FAIL rst_hold_pred got %b want 0", bp.pred_taken);
    end else n_pass++;
    rst = 1'b0;
    for (int a = 0; a < 64; a++) begin
      bp.pred_pc = 32'(a * 4);
      #1;
      n_tot++;
      if (bp.pred_taken !== 1'b0) begin
        $display("FAIL rst_pred pc=%h got %b want 0",
                 bp.pred_pc, bp.pred_taken);
      end else n_pass++;
    end
    n_tot++;
    if (bp.branch_cnt !== 4'd0 || bp.miss_cnt !== 4'd0) begin
      $display("FAIL rst_stats got %0d/%0d want 0/0",
               bp.branch_cnt, bp.miss_cnt);
    end else n_pass++;
  endtask

  task automatic test_train();
    logic [2:0] exp_pred;
    exp_pred = 3'b110;
    do_reset();
    bp.pred_pc = 32'h40;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tot++;
      if (bp.pred_taken !== exp_pred[i]) begin
        $display("FAIL train_pred step%0d got %b want %b",
                 i, bp.pred_taken, exp_pred[i]);
      end else n_pass++;
      bp.upd_valid = 1'b1;
      bp.upd_pc    = 32'h40;
      bp.upd_taken = 1'b1;
      bp.upd_pred  = exp_pred[i];
      #1;
      n_tot++;
      if (bp.mispredict !== (i == 0)) begin
        $display("FAIL train_miss step%0d got %b want %b",
                 i, bp.mispredict, (i == 0));
      end else n_pass++;
      @(posedge clk);
      #1 idle();
    end
    #1;
    n_tot++;
    if (bp.pred_taken !== 1'b1) begin
      $display("FAIL train_final got %b want 1", bp.pred_taken);
    end else n_pass++;
    n_tot++;
    if (bp.branch_cnt !== 4'd3 || bp.miss_cnt !== 4'd1) begin
      $display("FAIL train_stats got %0d/%0d want 3/1",
               bp.branch_cnt, bp.miss_cnt);
    end else n_pass++;
  endtask

  // Continues from counter 11 at 0x40 left by test_train
  task automatic test_hysteresis();
    bp.pred_pc = 32'h40;
    upd(32'h40, 1'b0, 1'b1);
    #1;
    n_tot++;
    if (bp.pred_taken !== 1'b1) begin
      $display("FAIL hyst_10 got %b want 1", bp.pred_taken);
    end else n_pass++;
    upd(32'h40, 1'b0, 1'b1);
    #1;
    n_tot++;
    if (bp.pred_taken !== 1'b0) begin
      $display("FAIL hyst_01 got %b want 0", bp.pred_taken);
    end else n_pass++;
    n_tot++;
    if (bp.branch_cnt !== 4'd5 || bp.miss_cnt !== 4'd3) begin
      $display("FAIL hyst_stats got %0d/%0d want 5/3",
               bp.branch_cnt, bp.miss_cnt);
    end else n_pass++;
  endtask

  task automatic test_low_sat();
    do_reset();
    bp.pred_pc = 32'h20;
    upd(32'h20, 1'b0, 1'b0);
    upd(32'h20, 1'b0, 1'b0);
    upd(32'h20, 1'b1, 1'b0);
    #1;
    n_tot++;
    if (bp.pred_taken !== 1'b0) begin
      $display("FAIL low_sat_01 got %b want 0", bp.pred_taken);
    end else n_pass++;
    upd(32'h20, 1'b1, 1'b0);
    #1;
    n_tot++;
    if (bp.pred_taken !== 1'b1) begin
      $display("FAIL low_sat_10 got %b want 1", bp.pred_taken);
    end else n_pass++;
  endtask

  task automatic test_alias();
    do_reset();
    upd(32'h40, 1'b1, 1'b0);
    upd(32'h40, 1'b1, 1'b1);
    bp.pred_pc = 32'h140;
    #1;
    n_tot++;
    if (bp.pred_taken !== 1'b1) begin
      $display("FAIL alias_140 got %b want 1", bp.pred_taken);
    end else n_pass++;
    bp.pred_pc = 32'h44;
    #1;
    n_tot++;
    if (bp.pred_taken !== 1'b0) begin
      $display("FAIL alias_44 got %b want 0", bp.pred_taken);
    end else n_pass++;
    bp.pred_pc = 32'h43;
    #1;
    n_tot++;
    if (bp.pred_taken !== 1'b1) begin
      $display("FAIL alias_lowbits got %b want 1", bp.pred_taken);
    end else n_pass++;
  endtask

  task automatic test_simultaneous();
    do_reset();
    bp.pred_pc   = 32'h80;
    bp.upd_valid = 1'b1;
    bp.upd_pc    = 32'h80;
    bp.upd_taken = 1'b1;
    bp.upd_pred  = 1'b0;
    #1;
    n_tot++;
    if (bp.pred_taken !== 1'b0) begin
      $display("FAIL simul_same got %b want 0", bp.pred_taken);
    end else n_pass++;
    @(posedge clk);
    #1 idle();
    #1;
    n_tot++;
    if (bp.pred_taken !== 1'b1) begin
      $display("FAIL simul_next got %b want 1", bp.pred_taken);
    end else n_pass++;
  endtask

  task automatic test_mispredict_comb();
    idle();
    bp.upd_pred  = 1'b1;
    bp.upd_taken = 1'b0;
    #1;
    n_tot++;
    if (bp.mispredict !== 1'b0) begin
      $display("FAIL miss_novalid got %b want 0", bp.mispredict);
    end else n_pass++;
    bp.upd_valid = 1'b1;
    bp.upd_pred  = 1'b0;
    #1;
    n_tot++;
    if (bp.mispredict !== 1'b0) begin
      $display("FAIL miss_agree got %b want 0", bp.mispredict);
    end else n_pass++;
    bp.upd_taken = 1'b1;
    #1;
    n_tot++;
    if (bp.mispredict !== 1'b1) begin
      $display("FAIL miss_differ got %b want 1", bp.mispredict);
    end else n_pass++;
    idle();
  endtask

  task automatic test_async_reset();
    do_reset();
    upd(32'h80, 1'b1, 1'b0);
    upd(32'h80, 1'b1, 1'b1);
    bp.pred_pc = 32'h80;
    bp.upd_valid = 1'b1;
    bp.upd_pc    = 32'h80;
    bp.upd_taken = 1'b1;
    bp.upd_pred  = 1'b0;
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    n_tot++;
    if (bp.pred_taken !== 1'b0) begin
      $display("FAIL async_pred got %b want 0", bp.pred_taken);
    end else n_pass++;
    n_tot++;
    if (bp.branch_cnt !== 4'd0 || bp.miss_cnt !== 4'd0) begin
      $display("FAIL async_stats got %0d/%0d want 0/0",
               bp.branch_cnt, bp.miss_cnt);
    end else n_pass++;
    @(posedge clk);
    #1;
    n_tot++;
    if (bp.branch_cnt !== 4'd0 || bp.pred_taken !== 1'b0) begin
      $display("FAIL async_hold got cnt=%0d pred=%b want 0/0",
               bp.branch_cnt, bp.pred_taken);
    end else n_pass++;
    idle();
    rst = 1'b0;
  endtask

  task automatic test_stat_sat();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      upd(32'h100, i[0], ~i[0]);
      if (i == 14) begin
        n_tot++;
        if (bp.branch_cnt !== 4'd15 || bp.miss_cnt !== 4'd15) begin
          $display("FAIL sat_reach got %0d/%0d want 15/15",
                   bp.branch_cnt, bp.miss_cnt);
        end else n_pass++;
      end
    end
    n_tot++;
    if (bp.branch_cnt !== 4'd15 || bp.miss_cnt !== 4'd15) begin
      $display("FAIL sat_hold got %0d/%0d want 15/15",
               bp.branch_cnt, bp.miss_cnt);
    end else n_pass++;
  endtask

  initial begin
    idle();
    bp.pred_pc = '0;
    test_reset();
    test_train();
    test_hysteresis();
    test_low_sat();
    test_alias();
    test_simultaneous();
    test_mispredict_comb();
    test_async_reset();
    test_stat_sat();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised dynamic branch predictor for the pipelined MIPS core.
- Replaces the static predict-not-taken scheme, in which every taken beq/bne costs an IF_Flush.
- Fetch stage looks up a table of saturating counters indexed by PC. ID stage reports resolved outcomes, which train the table.
- Block raises a flush request on mispredict and keeps branch/mispredict statistics for benchmarking.

Parameters:
- PC_W, 32, width of program counter.
- IDX_W, 6, index bits; table holds 2**IDX_W entries.
- CTR_W, 2, saturating counter width (min 1).
- STAT_W, 16, width of statistics counters.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- pred_pc  in  PC_W  PC of instruction in IF.
- pred_taken  out  1  prediction for pred_pc.
- upd_valid  in  1  a branch resolved in ID this cycle.
- upd_pc  in  PC_W  PC of the resolved branch.
- upd_pred  in  1  prediction originally given to that branch, carried down the pipeline.
- upd_taken  in  1  actual outcome (equal-compare result).
- mispredict  out  1  upd_valid & (upd_pred != upd_taken); drives flush/pcSrc correction.
- branch_cnt  out  STAT_W  number of resolved branches.
- miss_cnt  out  STAT_W  number of mispredicts.
- pred_ghr  out  IDX_W  current global history; only with GHISTORY_EN.
- upd_ghr  in  IDX_W  history captured at prediction time; only with GHISTORY_EN.

Behaviour:
- Index: idx(pc) = pc[IDX_W+1:2]. Word-aligned; bits [1:0] ignored.
- Table: 2**IDX_W counters of CTR_W bits.
- Reset (async, rst=1): every counter = 2**(CTR_W-1)-1 (weakly not-taken, 2'b01 for default). branch_cnt=0, miss_cnt=0, GHR=0.
  - While rst is held, pred_taken reflects the reset table, i.e. 0. mispredict is purely combinational on its inputs.
- Prediction:
  - Combinational, zero latency.
  - pred_taken = MSB of counter[idx(pred_pc)].
- Update on rising clk when upd_valid=1:
  - counter[idx(upd_pc)] += 1 if upd_taken and not at all-ones.
  - counter[idx(upd_pc)] -= 1 if !upd_taken and not at zero.
  - Saturating; no wrap.
- No update when upd_valid=0. upd_pc, upd_pred and upd_taken are then don't-care.
- Same-index read and update in one cycle: pred_taken shows the pre-update value. No bypass. New value is visible the following cycle.
- Statistics, on a clk edge with upd_valid:
  - branch_cnt += 1.
  - miss_cnt += 1 if mispredict.
  - Both saturate at all-ones and hold.
  - miss_cnt <= branch_cnt always.
- Reset mid-operation: asynchronous clear of all state regardless of upd_valid. No partial update survives.
- CTR_W=1: degenerates to 1-bit last-outcome predictor; same rules apply.

Optional Feature:
- Macro: BRANCH_PREDICTOR_GHISTORY_EN.
- Defined (gshare):
  - IDX_W-bit global history register GHR, reset 0.
  - Lookup index = idx(pred_pc) ^ GHR.
  - pred_ghr = GHR. Pipeline carries it with the branch and returns it as upd_ghr.
  - Update index = idx(upd_pc) ^ upd_ghr.
  - On each upd_valid edge: GHR <= {GHR[IDX_W-2:0], upd_taken}.
  - On mispredict the same shift applies; no separate repair beyond this.
- Undefined:
  - pred_ghr/upd_ghr ports absent; no GHR; plain PC indexing as above.

Test Plan:
- Reset: rst=1 for 5 cycles, then release; pred_pc=0x00,0x04,...,0xFC -> pred_taken=0 for all; branch_cnt=miss_cnt=0.
- Training to taken: 3 back-to-back upd_valid with upd_pc=0x40, upd_taken=1, upd_pred=current prediction.
  - Counter steps 01->10->11->11.
  - pred_taken(0x40)=1 from the cycle after the first update.
  - mispredict=1 only on the first update.
  - miss_cnt=1, branch_cnt=3.
- Hysteresis: from state 11 at 0x40, one upd_taken=0 -> counter 10, pred_taken still 1. A second -> 01, pred_taken=0.
- Aliasing (IDX_W=6): train 0x40 taken twice -> pred_taken(0x140)=1, since 0x140 shares index 0x10. pred_taken(0x44)=0.
- Simultaneous / async reset:
  - pred_pc=upd_pc=0x80 with upd_taken=1 from 01 -> pred_taken=0 that cycle, 1 next cycle.
  - Assert rst mid-cycle -> all counters and stats clear immediately, without waiting for a clk edge.
- Saturation (STAT_W=4): 20 updates, all mispredicted -> branch_cnt=miss_cnt=15 and hold.
  - With BRANCH_PREDICTOR_GHISTORY_EN: after taken,not-taken,taken, GHR=3'b101 in low bits, and lookup of 0x40 uses index 0x10^GHR.
